// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and writeback lane type for the
// scoreboarded register file.
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NREAD_DEF = 2;
    localparam int NWB       = 2;

    // A depth of 2 still needs one address bit.
    function automatic int calc_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    localparam int AW_DEF = calc_aw(DEPTH_DEF);

    typedef struct packed {
        logic                 wen;
        logic [AW_DEF-1:0]    wsel;
        logic [WIDTH_DEF-1:0] wdat;
    } wb_lane_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: issue sets, writeback clears, flush wipes.
// Also produces the issue stall, per-port pending flags and a busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter int AW       = calc_aw(DEPTH)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NWB-1:0]      wen_i,
    input  logic [NWB*AW-1:0]   wsel_i,
    input  logic [NREAD*AW-1:0] rsel_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_sel_i,
    input  logic                flush_i,
    output logic [NREAD-1:0]    rbusy_o,
    output logic                iss_stall_o,
    output logic [AW:0]         busy_cnt_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] hit_s;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             stall_s;
    logic             accept_s;

    // Which registers are being written back this cycle.
    always_comb begin
        hit_s = '0;
        for (int r = 0; r < DEPTH; r++) begin
            hit_s[r] = ((wen_i[0] && (wsel_i[0 +: AW]  == AW'(r))) ||
                        (wen_i[1] && (wsel_i[AW +: AW] == AW'(r)))) &&
                       !(ZERO_REG && (r == 0));
        end
    end

    // Issue is refused only while the destination is still pending.
    always_comb begin
        stall_s  = iss_en_i & ~flush_i & busy_q[iss_sel_i] & ~hit_s[iss_sel_i];
        accept_s = iss_en_i & ~flush_i & ~stall_s;
    end

    // Next busy vector: flush beats issue, issue beats a coincident writeback.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            busy_d = busy_q & ~hit_s;
            if (accept_s) begin
                busy_d[iss_sel_i] = 1'b1;
            end else begin
                busy_d[iss_sel_i] = busy_d[iss_sel_i];
            end
        end
        busy_d[0] = ZERO_REG ? 1'b0 : busy_d[0];
    end

    // Popcount of the next state so the count tracks busy on the same edge.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // Pending flag per read port; a same-cycle writeback is served by bypass.
    always_comb begin
        rbusy_o = '0;
        for (int i = 0; i < NREAD; i++) begin
            rbusy_o[i] = busy_q[rsel_i[i*AW +: AW]] & ~hit_s[rsel_i[i*AW +: AW]];
        end
    end

    // Busy vector and count registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign iss_stall_o = stall_s;
    assign busy_cnt_o  = cnt_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with two prioritised write lanes, same-cycle
// write-to-read bypass and a busy scoreboard for issue hazard detection.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = calc_aw(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREAD*AW-1:0]    rsel,
    output logic [NREAD*WIDTH-1:0] rdat,
    output logic [NREAD-1:0]       rbusy,
    input  logic [NWB-1:0]         wen,
    input  logic [NWB*AW-1:0]      wsel,
    input  logic [NWB*WIDTH-1:0]   wdat,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_sel,
    output logic                   iss_stall,
    input  logic                   flush,
    output logic [AW:0]            busy_cnt
);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [NREAD*WIDTH-1:0] rdat_s;

    // Lane 1 is applied after lane 0 so it wins on an address clash.
    always_comb begin
        mem_d = mem_q;
        for (int l = 0; l < NWB; l++) begin
            mem_d[wsel[l*AW +: AW]] =
                (wen[l] && !(ZERO_REG && (wsel[l*AW +: AW] == {AW{1'b0}})))
                ? wdat[l*WIDTH +: WIDTH] : mem_d[wsel[l*AW +: AW]];
        end
    end

    // Storage array.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read mux: zero register first, then lane 1, lane 0, storage.
    always_comb begin
        rdat_s = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (ZERO_REG && (rsel[i*AW +: AW] == {AW{1'b0}})) begin
                rdat_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else if (wen[1] && (wsel[AW +: AW] == rsel[i*AW +: AW])) begin
                rdat_s[i*WIDTH +: WIDTH] = wdat[WIDTH +: WIDTH];
            end else if (wen[0] && (wsel[0 +: AW] == rsel[i*AW +: AW])) begin
                rdat_s[i*WIDTH +: WIDTH] = wdat[0 +: WIDTH];
            end else begin
                rdat_s[i*WIDTH +: WIDTH] = mem_q[rsel[i*AW +: AW]];
            end
        end
    end

    assign rdat = rdat_s;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .CLK         (CLK),
        .nRST        (nRST),
        .wen_i       (wen),
        .wsel_i      (wsel),
        .rsel_i      (rsel),
        .iss_en_i    (iss_en),
        .iss_sel_i   (iss_sel),
        .flush_i     (flush),
        .rbusy_o     (rbusy),
        .iss_stall_o (iss_stall),
        .busy_cnt_o  (busy_cnt)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb at default parameters.
module tb_register_file_sb;
    import regfile_pkg::*;

    localparam int AW = AW_DEF;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [2*AW-1:0]     rsel;
    logic [63:0]         rdat;
    logic [1:0]          rbusy;
    logic                iss_en;
    logic [AW-1:0]       iss_sel;
    logic                iss_stall;
    logic                flush;
    logic [AW:0]         busy_cnt;
    wb_lane_t            ln0, ln1;

    int n_cmp = 0;
    int n_bad = 0;

    register_file_sb dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .rsel      (rsel),
        .rdat      (rdat),
        .rbusy     (rbusy),
        .wen       ({ln1.wen, ln0.wen}),
        .wsel      ({ln1.wsel, ln0.wsel}),
        .wdat      ({ln1.wdat, ln0.wdat}),
        .iss_en    (iss_en),
        .iss_sel   (iss_sel),
        .iss_stall (iss_stall),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ln0 = '0; ln1 = '0; iss_en = 1'b0; iss_sel = '0; flush = 1'b0;
    endtask

    task automatic rd(input int a, input int b);
        rsel = {AW'(b), AW'(a)};
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        rsel = '0;
        idle();
        #12;
        for (int r = 0; r < 32; r++) begin
            rd(r, 31 - r);
            check("reset_rdat", rdat, 64'h0);
            check("reset_rbusy", {62'h0, rbusy}, 64'h0);
        end
        check("reset_cnt", {58'h0, busy_cnt}, 64'h0);
        nRST = 1'b1;
        step();

        // Lane 0 write with same-cycle bypass, then storage read.
        ln0 = '{wen: 1'b1, wsel: 5'd5, wdat: 32'hDEADBEEF};
        rd(5, 6);
        check("bypass_l0", {32'h0, rdat[31:0]}, 64'hDEADBEEF);
        check("bypass_other", {32'h0, rdat[63:32]}, 64'h0);
        step(); idle(); rd(5, 5);
        check("store_r5", rdat, 64'hDEADBEEF_DEADBEEF);

        // Same-address clash: lane 1 wins.
        ln0 = '{wen: 1'b1, wsel: 5'd7, wdat: 32'h1};
        ln1 = '{wen: 1'b1, wsel: 5'd7, wdat: 32'h2};
        rd(5, 7);
        check("clash_bypass", {32'h0, rdat[63:32]}, 64'h2);
        step(); idle(); rd(7, 7);
        check("clash_store", rdat, 64'h2_00000002);

        // Distinct lanes: each port sees its own lane.
        ln0 = '{wen: 1'b1, wsel: 5'd12, wdat: 32'hC0C0};
        ln1 = '{wen: 1'b1, wsel: 5'd13, wdat: 32'hD0D0};
        rd(12, 13);
        check("two_lane_bypass", rdat, 64'hD0D0_0000C0C0);
        step(); idle(); rd(12, 13);
        check("two_lane_store", rdat, 64'hD0D0_0000C0C0);

        // Zero register: write and issue are ignored.
        ln0 = '{wen: 1'b1, wsel: 5'd0, wdat: 32'hFFFFFFFF};
        iss_en = 1'b1; iss_sel = 5'd0;
        rd(0, 0);
        check("r0_bypass", rdat, 64'h0);
        check("r0_stall", {63'h0, iss_stall}, 64'h0);
        step(); idle(); rd(0, 0);
        check("r0_store", rdat, 64'h0);
        check("r0_rbusy", {62'h0, rbusy}, 64'h0);
        check("r0_cnt", {58'h0, busy_cnt}, 64'h0);

        // Issue r3, re-issue stalls, writeback releases the stall.
        iss_en = 1'b1; iss_sel = 5'd3;
        rd(3, 4);
        check("iss3_stall0", {63'h0, iss_stall}, 64'h0);
        step(); idle(); rd(3, 4);
        check("iss3_rbusy", {62'h0, rbusy}, 64'h1);
        check("iss3_cnt", {58'h0, busy_cnt}, 64'h1);
        iss_en = 1'b1; iss_sel = 5'd3;
        #1;
        check("waw_stall", {63'h0, iss_stall}, 64'h1);
        step();
        check("held_stall", {63'h0, iss_stall}, 64'h1);
        check("held_cnt", {58'h0, busy_cnt}, 64'h1);
        ln1 = '{wen: 1'b1, wsel: 5'd3, wdat: 32'h33};
        #1;
        check("wb_unstall", {63'h0, iss_stall}, 64'h0);
        check("wb_rbusy", {62'h0, rbusy}, 64'h0);
        check("wb_bypass", {32'h0, rdat[31:0]}, 64'h33);
        step(); idle(); rd(3, 4);
        check("reissue_rbusy", {62'h0, rbusy}, 64'h1);
        check("reissue_cnt", {58'h0, busy_cnt}, 64'h1);
        check("reissue_data", {32'h0, rdat[31:0]}, 64'h33);

        // Plain writeback clears busy; writeback to an idle register is harmless.
        ln0 = '{wen: 1'b1, wsel: 5'd3, wdat: 32'h44};
        ln1 = '{wen: 1'b1, wsel: 5'd9, wdat: 32'h99};
        step(); idle(); rd(3, 9);
        check("wb_clear_rbusy", {62'h0, rbusy}, 64'h0);
        check("wb_clear_cnt", {58'h0, busy_cnt}, 64'h0);
        check("wb_clear_data", rdat, 64'h99_00000044);

        // Three issues, then flush with a competing issue and a write.
        iss_en = 1'b1; iss_sel = 5'd1; step();
        iss_sel = 5'd2; step();
        iss_sel = 5'd4; step();
        idle(); rd(1, 4);
        check("three_cnt", {58'h0, busy_cnt}, 64'h3);
        check("three_rbusy", {62'h0, rbusy}, 64'h3);
        flush = 1'b1; iss_en = 1'b1; iss_sel = 5'd6;
        ln1 = '{wen: 1'b1, wsel: 5'd10, wdat: 32'hAA};
        #1;
        check("flush_stall", {63'h0, iss_stall}, 64'h0);
        step(); idle();
        check("flush_cnt", {58'h0, busy_cnt}, 64'h0);
        rd(1, 2);
        check("flush_rb_1_2", {62'h0, rbusy}, 64'h0);
        rd(4, 6);
        check("flush_rb_4_6", {62'h0, rbusy}, 64'h0);
        rd(10, 6);
        check("flush_write", {32'h0, rdat[31:0]}, 64'hAA);

        // Asynchronous reset in the middle of a cycle.
        iss_en = 1'b1; iss_sel = 5'd8;
        ln0 = '{wen: 1'b1, wsel: 5'd9, wdat: 32'h55};
        step(); idle(); rd(8, 9);
        check("pre_rst_rbusy", {62'h0, rbusy}, 64'h1);
        check("pre_rst_data", {32'h0, rdat[63:32]}, 64'h55);
        nRST = 1'b0;
        #1;
        check("async_cnt", {58'h0, busy_cnt}, 64'h0);
        check("async_rbusy", {62'h0, rbusy}, 64'h0);
        check("async_data", rdat, 64'h0);
        rd(5, 13);
        check("async_data2", rdat, 64'h0);
        step();
        nRST = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Provides NREAD read ports and two write ports with fixed priority, plus same-cycle write-to-read bypass.
- Holds a per-register busy scoreboard, set at issue and cleared at writeback, with a flush.
- Sits between decode/issue (read, issue, stall) and writeback (two retire lanes) in the pipelined datapath.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; power of two, ≥ 2. AW = $clog2(DEPTH).
- NREAD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 is hard-wired zero.

Ports:
- CLK  in  1  rising-edge clock.
- nRST  in  1  asynchronous active-low reset.
- rsel  in  NREAD x AW  read address per port.
- rdat  out  NREAD x WIDTH  read data per port, combinational.
- rbusy  out  NREAD  per read port: the value is still pending.
- wen  in  2  write enable per write lane.
- wsel  in  2 x AW  write address per lane.
- wdat  in  2 x WIDTH  write data per lane.
- iss_en  in  1  issue request: mark iss_sel busy.
- iss_sel  in  AW  destination register of the issuing instruction.
- iss_stall  out  1  issue refused this cycle (WAW hazard).
- flush  in  1  clear all busy bits.
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
- Reset (async, nRST low): all registers = 0, all busy bits = 0, busy_cnt = 0. rdat reflects reset contents, so rdat = 0 and rbusy = 0.
- Write: on CLK rise, each lane with wen=1 writes wdat into wsel.
- Same-address write conflict: if both lanes write the same address, lane 1 wins.
- Zero register (ZERO_REG=1): writes to reg 0 are dropped; reads of reg 0 return 0; reg 0 is never busy; issue to reg 0 is always accepted and has no effect.
- Read bypass, combinational, per port i, in priority order:
  - lane 1 writing rsel[i] -> wdat[1];
  - else lane 0 writing rsel[i] -> wdat[0];
  - else stored value.
  - Zero-register override applies last.
- Writeback hit: wb_hit(r) = (wen[0] & wsel[0]==r) | (wen[1] & wsel[1]==r), excluding r=0 when ZERO_REG.
- rbusy[i] = busy[rsel[i]] & ~wb_hit(rsel[i]). A same-cycle writeback is consumed through the bypass.
- iss_stall = iss_en & ~flush & busy[iss_sel] & ~wb_hit(iss_sel). It is combinational; the producer holds iss_en/iss_sel until the stall drops.
- Busy update on CLK rise, with precedence flush > issue > writeback:
  - flush=1 -> all busy = 0. iss_en is ignored that cycle; writes still commit.
  - Else, issue accepted (iss_en & ~iss_stall) -> busy[iss_sel] = 1, even if the same register is written back this cycle (the new producer owns it).
  - Other registers with wb_hit -> busy = 0.
- Writeback to a non-busy register is legal: data is written and busy is unchanged at 0.
- busy_cnt: registered popcount of next busy state, updated the same edge as busy; equals 0 one cycle after flush. Range 0..DEPTH-ZERO_REG.
- Latency: write visible on rdat in the same cycle via bypass and from storage thereafter. Busy set by issue is visible on rbusy/iss_stall the next cycle.
- Reset mid-operation: all state cleared immediately; in-flight issues are lost and no recovery is required.

Decomposition:
- Package regfile_pkg holds:
  - WIDTH/DEPTH/NREAD defaults and an AW helper function;
  - the wb_lane_t struct (wen, wsel, wdat);
  - localparam NWB = 2.
- Sub-module regfile_scoreboard holds the busy vector, the wb_hit, iss_stall and rbusy logic, and busy_cnt.
- Storage and the bypass mux stay in the top module.

Test Plan:
- Reset, then read all registers on every port -> rdat = 0, rbusy = 0, busy_cnt = 0. Assert nRST low mid-run -> state cleared without waiting for a clock edge.
- Write lane 0 r5 = 0xDEADBEEF and read r5 in the same cycle -> rdat = 0xDEADBEEF (bypass); next cycle read from storage is also 0xDEADBEEF.
- Both lanes write r7 (lane0 = 0x1, lane1 = 0x2) -> same-cycle read = 0x2; stored value = 0x2.
- ZERO_REG=1: write r0 = 0xFFFFFFFF and issue r0 -> rdat(r0) = 0, iss_stall = 0, busy_cnt unchanged.
- Issue r3 -> next cycle rbusy(r3) = 1 and busy_cnt = 1. Issue r3 again -> iss_stall = 1. Writeback r3 the same cycle -> iss_stall = 0, the issue is accepted, and busy[r3] stays 1.
- Issue r1, r2, r4 on consecutive cycles (busy_cnt = 3), then flush together with iss_en r6 -> next cycle busy_cnt = 0 and rbusy = 0 for r1/r2/r4/r6.
